// File: rtl/nco_pkg.sv
// Shared types and elaboration-time helpers for the quadrature NCO.
// The quarter-wave table is computed here so the ROM needs no external init file.
package nco_pkg;

    typedef logic [1:0] quadrant_t;

    localparam int unsigned LutDepthDefault = 8;
    localparam int unsigned QuarterLen      = 1 << (LutDepthDefault - 2);

    localparam real Pi = 3.14159265358979323846;

    function automatic int unsigned quarter_len(input int unsigned lut_depth);
        return 1 << (lut_depth - 2);
    endfunction

    // Half-step sampling keeps every quadrant symmetric, so negation cannot overflow.
    function automatic int quarter_sine(input int k, input int data_width, input int lut_depth);
        real amp;
        real ang;
        amp = real'((1 << (data_width - 1)) - 1);
        ang = Pi * real'(2 * k + 1) / real'(1 << lut_depth);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/nco_quadrature_if.sv
// Sample-strobe, tuning and output bundle of the quadrature NCO.
interface nco_quadrature_if #(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned PHASE_WIDTH = 32
);
    logic                          sample_clk_ce;
    logic [PHASE_WIDTH-1:0]        phase_increment;
    logic                          freq_load;
    logic [PHASE_WIDTH-1:0]        phase_offset;
    logic                          sync_clear;
    logic signed [DATA_WIDTH-1:0]  sin_out;
    logic signed [DATA_WIDTH-1:0]  cos_out;
    logic                          out_valid;

    modport master (
        output sample_clk_ce, phase_increment, freq_load, phase_offset, sync_clear,
        input  sin_out, cos_out, out_valid
    );

    modport slave (
        input  sample_clk_ce, phase_increment, freq_load, phase_offset, sync_clear,
        output sin_out, cos_out, out_valid
    );
endinterface

// File: rtl/nco_quarter_rom.sv
// Dual-read-port quarter-wave sine table with registered outputs.
module nco_quarter_rom
    import nco_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned LUT_DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic [LUT_DEPTH-3:0]    sin_addr,
    input  logic [LUT_DEPTH-3:0]    cos_addr,
    output logic [DATA_WIDTH-1:0]   sin_data,
    output logic [DATA_WIDTH-1:0]   cos_data
);

    localparam int unsigned RomLen = quarter_len(LUT_DEPTH);

    logic [DATA_WIDTH-1:0] rom_mem [RomLen];

    for (genvar k = 0; k < RomLen; k++) begin : g_rom
        assign rom_mem[k] = DATA_WIDTH'(quarter_sine(k, DATA_WIDTH, LUT_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            sin_data <= '0;
            cos_data <= '0;
        end else begin
            sin_data <= rom_mem[sin_addr];
            cos_data <= rom_mem[cos_addr];
        end
    end

endmodule

// File: rtl/nco_quadrature.sv
// Quadrature NCO: phase accumulator, quadrant decode, shared quarter ROM and
// a 3-stage output pipeline whose valid bit travels with the data.
module nco_quadrature
    import nco_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned LUT_DEPTH   = 8,
    parameter int unsigned PHASE_WIDTH = 32
) (
    input logic              clk,
    input logic              arst_n,
    nco_quadrature_if.slave  bus
);

    localparam int unsigned AddrWidth = LUT_DEPTH - 2;

    logic [PHASE_WIDTH-1:0] acc_q, acc_d, inc_q, inc_d, phase;
    logic [LUT_DEPTH-1:0]   sin_addr, cos_addr;
    quadrant_t              sin_quad, cos_quad;
    logic [AddrWidth-1:0]   sin_idx_d, cos_idx_d, sin_idx_q, cos_idx_q;
    logic [1:0]             neg_s1_q, neg_s2_q;  // {cos, sin}
    logic [2:0]             valid_q;
    logic [DATA_WIDTH-1:0]  sin_rom, cos_rom, sin_q, cos_q;

    always_comb begin
        acc_d = acc_q;
        if (bus.sync_clear) begin
            acc_d = '0;
        end else if (bus.sample_clk_ce) begin
            acc_d = acc_q + inc_q;
        end
        inc_d = bus.freq_load ? bus.phase_increment : inc_q;
    end

    // Sampled phase uses the pre-update accumulator.
    always_comb begin
        phase     = acc_q + bus.phase_offset;
        sin_addr  = LUT_DEPTH'(phase >> (PHASE_WIDTH - LUT_DEPTH));
        cos_addr  = sin_addr + LUT_DEPTH'(1 << AddrWidth);
        sin_quad  = sin_addr[LUT_DEPTH-1 -: 2];
        cos_quad  = cos_addr[LUT_DEPTH-1 -: 2];
        sin_idx_d = sin_quad[0] ? ~sin_addr[AddrWidth-1:0] : sin_addr[AddrWidth-1:0];
        cos_idx_d = cos_quad[0] ? ~cos_addr[AddrWidth-1:0] : cos_addr[AddrWidth-1:0];
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            acc_q     <= '0;
            inc_q     <= '0;
            sin_idx_q <= '0;
            cos_idx_q <= '0;
            neg_s1_q  <= '0;
            neg_s2_q  <= '0;
            valid_q   <= '0;
            sin_q     <= '0;
            cos_q     <= '0;
        end else begin
            acc_q     <= acc_d;
            inc_q     <= inc_d;
            sin_idx_q <= sin_idx_d;
            cos_idx_q <= cos_idx_d;
            neg_s1_q  <= {cos_quad[1], sin_quad[1]};
            neg_s2_q  <= neg_s1_q;
            valid_q   <= {valid_q[1:0], bus.sample_clk_ce};
            // Outputs hold between samples.
            if (valid_q[1]) begin
                sin_q <= neg_s2_q[0] ? -sin_rom : sin_rom;
                cos_q <= neg_s2_q[1] ? -cos_rom : cos_rom;
            end
        end
    end

    nco_quarter_rom #(
        .DATA_WIDTH (DATA_WIDTH),
        .LUT_DEPTH  (LUT_DEPTH)
    ) u_rom (
        .clk      (clk),
        .arst_n   (arst_n),
        .sin_addr (sin_idx_q),
        .cos_addr (cos_idx_q),
        .sin_data (sin_rom),
        .cos_data (cos_rom)
    );

    assign bus.sin_out   = sin_q;
    assign bus.cos_out   = cos_q;
    assign bus.out_valid = valid_q[2];

endmodule

// File: tb/tb_nco_quadrature.sv
// Scoreboard bench for nco_quadrature: a phase model predicts each sample from
// ideal sin/cos of the half-step address and checks it at the expected cycle.
module tb_nco_quadrature;

    localparam real Pi = 3.14159265358979323846;

    typedef struct {
        int cyc;
        int s;
        int c;
    } exp_t;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    bit   mon_en = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t sb[$];
    int   got_sin[$];
    int   got_cos[$];
    int   ref_cos[$];
    int   last_s = 0;
    int   last_c = 0;

    logic [31:0] m_acc = '0;
    logic [31:0] m_inc = '0;

    nco_quadrature_if #(.DATA_WIDTH(12), .PHASE_WIDTH(32)) bus ();

    nco_quadrature #(
        .DATA_WIDTH  (12),
        .LUT_DEPTH   (8),
        .PHASE_WIDTH (32)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int round_wave(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    // Drive one cycle; the model predicts the emitted sample and updates its state.
    task automatic drive(input bit ce, input bit fl, input bit sc,
                         input logic [31:0] inc, input logic [31:0] off);
        logic [31:0] p;
        real         ang;
        exp_t        e;
        bus.sample_clk_ce   = ce;
        bus.freq_load       = fl;
        bus.sync_clear      = sc;
        bus.phase_increment = inc;
        bus.phase_offset    = off;
        if (ce) begin
            p     = m_acc + off;
            ang   = 2.0 * Pi * (real'(p[31:24]) + 0.5) / 256.0;
            e.cyc = cyc + 3;
            e.s   = round_wave(2047.0 * $sin(ang));
            e.c   = round_wave(2047.0 * $cos(ang));
            sb.push_back(e);
        end
        if (sc) m_acc = '0;
        else if (ce) m_acc = m_acc + m_inc;
        if (fl) m_inc = inc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bit   exp_v;
            exp_t e;
            int   pw;
            exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
            check_eq("out_valid", longint'(bus.out_valid), longint'(exp_v));
            if (exp_v) begin
                e = sb.pop_front();
                check_eq("sin_out", longint'(bus.sin_out), longint'(e.s));
                check_eq("cos_out", longint'(bus.cos_out), longint'(e.c));
                got_sin.push_back(int'(bus.sin_out));
                got_cos.push_back(int'(bus.cos_out));
                pw = int'(bus.sin_out) * int'(bus.sin_out) + int'(bus.cos_out) * int'(bus.cos_out);
                check_eq("power_1pct", longint'(pw > 4148307 && pw < 4232111), 1);
                last_s = e.s;
                last_c = e.c;
            end else begin
                check_eq("sin_hold", longint'(bus.sin_out), longint'(last_s));
                check_eq("cos_hold", longint'(bus.cos_out), longint'(last_c));
            end
        end
    end

    initial begin
        bus.sample_clk_ce   = 1'b0;
        bus.freq_load       = 1'b0;
        bus.sync_clear      = 1'b0;
        bus.phase_increment = '0;
        bus.phase_offset    = '0;

        // Reset with random inputs: everything must read zero.
        for (int i = 0; i < 5; i++) begin
            bus.sample_clk_ce   = 1'($urandom);
            bus.freq_load       = 1'($urandom);
            bus.sync_clear      = 1'($urandom);
            bus.phase_increment = $urandom;
            bus.phase_offset    = $urandom;
            @(posedge clk);
            #1;
            cyc++;
            check_eq("rst_sin", longint'(bus.sin_out), 0);
            check_eq("rst_cos", longint'(bus.cos_out), 0);
            check_eq("rst_valid", longint'(bus.out_valid), 0);
        end
        arst_n = 1'b1;
        mon_en = 1'b1;
        idle(1);

        // Full cycle at 256 samples per turn.
        drive(1'b0, 1'b1, 1'b0, 32'h0100_0000, 32'h0);
        got_sin.delete();
        got_cos.delete();
        for (int i = 0; i < 256; i++) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(4);
        check_eq("full_count", longint'(got_sin.size()), 256);
        if (got_sin.size() == 256) begin
            check_eq("sin_s0", longint'(got_sin[0]), 25);
            check_eq("sin_s63", longint'(got_sin[63]), 2047);
            check_eq("sin_s64", longint'(got_sin[64]), 2047);
            check_eq("sin_s128", longint'(got_sin[128]), -25);
            check_eq("sin_s192", longint'(got_sin[192]), -2047);
            check_eq("cos_s0", longint'(got_cos[0]), 2047);
        end
        ref_cos = got_cos;

        // Quarter-turn offset: sine tracks the zero-offset cosine.
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        got_sin.delete();
        got_cos.delete();
        for (int i = 0; i < 256; i++) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h4000_0000);
        idle(4);
        check_eq("offset_count", longint'(got_sin.size()), 256);
        if (got_sin.size() == 256 && ref_cos.size() == 256) begin
            for (int i = 0; i < 256; i++)
                check_eq("offset_sin_vs_cos", longint'(got_sin[i]), longint'(ref_cos[i]));
        end

        // Frequency load colliding with a strobe.
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        got_sin.delete();
        got_cos.delete();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0200_0000, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(4);
        check_eq("coll_count", longint'(got_sin.size()), 4);
        if (got_sin.size() == 4) begin
            check_eq("coll_addr2", longint'(got_sin[2]), 126);
            check_eq("coll_addr4", longint'(got_sin[3]), 226);
        end

        // Clear together with a strobe mid-cycle.
        drive(1'b0, 1'b1, 1'b0, 32'h0100_0000, 32'h0);
        got_sin.delete();
        got_cos.delete();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(4);
        check_eq("clr_count", longint'(got_sin.size()), 7);
        if (got_sin.size() == 7) begin
            check_eq("clr_old_phase", longint'(got_sin[5] != 25), 1);
            check_eq("clr_next_sin", longint'(got_sin[6]), 25);
        end

        // Sparse strobes with a backward step wrapping through zero.
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0);
        got_sin.delete();
        got_cos.delete();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            idle(2);
        end
        idle(4);
        check_eq("gap_count", longint'(got_sin.size()), 12);
        if (got_sin.size() == 12) begin
            check_eq("gap_first", longint'(got_sin[0]), 25);
            check_eq("gap_wrap", longint'(got_sin[1]), -25);
            check_eq("gap_last", longint'(got_sin[11]), -25);
        end

        check_eq("sb_drained", longint'(sb.size()), 0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_quadrature.md
# nco_quadrature

Parametrised quadrature numerically controlled oscillator (NCO) that produces phase-coherent signed sine and cosine samples. It stores only a quarter-wave lookup table. It adds a run-time phase offset, a glitch-free frequency load and a synchronous phase clear. It drives SDR mixer and modulator stages, and its output is qualified by a valid strobe so it can be throttled by a sample-rate clock enable.

## Interface
- DATA_WIDTH, 12: width of `sin_out` and `cos_out`, two's complement.
- LUT_DEPTH, 8: phase bits used for lookup (2^LUT_DEPTH points per cycle). The quarter table holds 2^(LUT_DEPTH-2) entries. Minimum value is 3.
- PHASE_WIDTH, 32: width of the phase accumulator, increment and offset. Must be ≥ LUT_DEPTH.

Ports:
- clk  in  1: system clock, rising edge.
- arst_n  in  1: reset, synchronous, active-low.
- sample_clk_ce  in  1: sample strobe. Each high cycle emits one sample and advances the phase.
- phase_increment  in  PHASE_WIDTH: unsigned tuning word. It is captured only when `freq_load` is high.
- freq_load  in  1: latches `phase_increment` into the active increment register.
- phase_offset  in  PHASE_WIDTH: unsigned phase offset, added combinationally every cycle. Not registered.
- sync_clear  in  1: forces the phase accumulator to 0.
- sin_out  out  DATA_WIDTH: signed sine sample.
- cos_out  out  DATA_WIDTH: signed cosine sample.
- out_valid  out  1: asserted for one clk cycle per emitted sample.

## Operation
- Phase accumulator `acc`:
  - When `sample_clk_ce` is high: `acc <= acc + inc_active`, modulo 2^PHASE_WIDTH. Wrap-around is silent.
  - When `sync_clear` is high: `acc <= 0`. This overrides the increment in the same cycle.
- Active increment: `inc_active <= phase_increment` when `freq_load` is high.
  - If `freq_load` and `sample_clk_ce` are both high in the same cycle, that sample's accumulator update uses the old `inc_active`.
- Sampled phase: `p = acc + phase_offset`, modulo 2^PHASE_WIDTH, taken using the pre-update `acc`.
  - Top LUT_DEPTH bits of `p` form the address `a`.
  - The sample emitted on the cycle `sync_clear` rises uses the pre-clear phase. The next sample has phase `0 + phase_offset`.
- Quadrant decode for sine:
  - q = a[MSB:MSB-1]; i = low LUT_DEPTH-2 bits of `a`.
  - Table index = i when q[0] = 0, otherwise ~i (mirror).
  - Negate the table value when q[1] = 1.
- Cosine uses the same decode on address a + 2^(LUT_DEPTH-2), modulo 2^LUT_DEPTH.
- Quarter table entry k = round((2^(DATA_WIDTH-1)-1) · sin(π(2k+1)/2^LUT_DEPTH)).
  - The half-step offset makes every quadrant exactly symmetric, so negation never overflows.
  - Output range is ±(2^(DATA_WIDTH-1)-1). The most negative code is never produced.
- Reset (`arst_n` = 0 at a clk edge): `acc`, `inc_active`, all pipeline registers, `sin_out`, `cos_out` and `out_valid` all go to 0.
  - Samples in flight are discarded. The inputs are ignored during reset.

## Timing
- Pipeline is 3 stages, advances every clk and is not gated by `sample_clk_ce`. Valid is carried alongside the data.
  - S1: register the sine and cosine table indices and the negate flags.
  - S2: register the ROM reads.
  - S3: apply conditional negation and register the outputs.
- Latency: `sample_clk_ce` high in cycle n makes `out_valid` high in cycle n+3, with that sample on `sin_out`/`cos_out`.
- Throughput: one sample per clk. Back-to-back `sample_clk_ce` is legal.
- `sin_out` and `cos_out` hold their value while `out_valid` is low.
- `freq_load` in cycle n affects accumulator updates from cycle n+1 onward.
- Changing `phase_offset` at cycle n affects the sample strobed at cycle n, i.e. the output at n+3.
- Reset released at cycle r: the first `sample_clk_ce` accepted is in cycle r+1 or later.

## Structure
- Package `nco_pkg`:
  - `quarter_sine` function that computes table entries from DATA_WIDTH and LUT_DEPTH at elaboration time.
  - `quadrant_t` 2-bit typedef.
  - Localparam for the quarter length.
- Sub-module `nco_quarter_rom`:
  - Dual read port (sine and cosine), synchronous read, initialised from `nco_pkg::quarter_sine`.
  - Maps to a single dual-port block RAM or ROM.
- Top level holds the accumulator, the increment register, the quadrant decode, the negation stage and the valid shift register.

## Test plan
All scenarios use the default parameters.
- **Reset:** hold `arst_n` low for 5 cycles with random inputs → `sin_out` = `cos_out` = 0 and `out_valid` = 0 throughout; first valid appears 3 cycles after the first post-reset `sample_clk_ce`.
- **Full cycle:** `freq_load` with increment 0x0100_0000, then continuous `sample_clk_ce` → exactly 256 samples per cycle.
  - Samples 0, 63, 64, 128, 192 give `sin_out` = 25, 2047, 2047, −25, −2047.
  - Sample 0 gives `cos_out` = 2047.
  - `sin_out`² + `cos_out`² stays within ±1 % of 2047² on every sample.
- **Phase offset:** same increment with offset 0x4000_0000 → `sin_out` equals the zero-offset `cos_out` sample-for-sample.
- **Frequency load collision:** `freq_load` (increment 0x0200_0000) in the same cycle as `sample_clk_ce` → the next phase step is still 0x0100_0000; subsequent steps are 0x0200_0000.
- **Clear and ce together:** `sync_clear` with `sample_clk_ce` mid-cycle → that sample keeps the old phase; the following sample returns `sin_out` = 25.
- **Gaps and wrap:** `sample_clk_ce` every 3rd cycle with increment 0xFFFF_FFFF → `out_valid` one cycle in three; phase steps backward by 1 LSB with correct modular wrap from 0 to 0xFFFF_FFFF.
